// File: rtl/fft_agu_seq_if.sv
// Address stream from the FFT AGU to the butterfly/memory controller.
// One tuple per transfer: two operand addresses, twiddle index, stage and last-pair flag.
interface fft_agu_seq_if #(
  parameter int N = 1024
);
  localparam int LOG2N = $clog2(N);

  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] address1;
  logic [LOG2N-1:0] address2;
  logic [LOG2N-2:0] twiddle_addr;
  logic [LOG2N-1:0] stage_out;
  logic             last_in_stage;

  modport master (
    output out_valid, address1, address2, twiddle_addr, stage_out, last_in_stage,
    input  out_ready
  );

  modport slave (
    input  out_valid, address1, address2, twiddle_addr, stage_out, last_in_stage,
    output out_ready
  );
endinterface

// File: rtl/fft_agu_seq.sv
// Self-sequencing radix-2 FFT address generator: walks every (stage, pair) of a
// runtime-sized transform and streams operand/twiddle addresses with backpressure.
module fft_agu_seq #(
  parameter int N = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [$clog2(N)-1:0]   log_n,
  output logic                   busy,
  output logic                   done,
  fft_agu_seq_if.master          bus
);
  localparam int LOG2N = $clog2(N);
  localparam int PW    = LOG2N - 1;
  localparam logic [LOG2N-1:0] LOG2N_V = LOG2N'(LOG2N);
  localparam logic [LOG2N-1:0] ONE     = LOG2N'(1);
  localparam logic [LOG2N-1:0] TWO     = LOG2N'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [LOG2N-1:0] n_q, n_d, n_clamped;
  logic [PW-1:0]    pair_q, pair_d, pair_max;
  logic             xfer, last_pair, final_pair, load;

  logic             busy_d, valid_d, done_d;
  logic [LOG2N-1:0] addr1_d, addr2_d;
  logic [PW-1:0]    tw_d, tw_keep;
  logic [LOG2N-1:0] tw_shift;

  logic             busy_q, valid_q, done_q, last_q;
  logic [LOG2N-1:0] addr1_q, addr2_q, stage_out_q;
  logic [PW-1:0]    tw_q;

  // Left rotation confined to the low n bits; s is always below n.
  function automatic logic [LOG2N-1:0] rotl_n(input logic [LOG2N-1:0] x,
                                              input logic [LOG2N-1:0] s,
                                              input logic [LOG2N-1:0] n);
    logic [LOG2N-1:0] mask;
    mask = ~({LOG2N{1'b1}} << n);
    return ((x << s) | (x >> (n - s))) & mask;
  endfunction

  assign n_clamped  = (log_n < TWO) ? TWO : ((log_n > LOG2N_V) ? LOG2N_V : log_n);
  assign pair_max   = ~({PW{1'b1}} << (n_q - ONE));
  assign last_pair  = (pair_q == pair_max);
  assign final_pair = last_pair && (stage_q == n_q - ONE);
  assign xfer       = valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (xfer && final_pair) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == RUN);
    valid_d = (state_d == RUN);
    done_d  = (state_q == RUN) && (state_d == IDLE);
  end

  // Counters describe the tuple that will be presented after the next edge.
  always_comb begin
    stage_d = stage_q;
    pair_d  = pair_q;
    n_d     = n_q;
    load    = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        n_d     = n_clamped;
        stage_d = '0;
        pair_d  = '0;
        load    = 1'b1;
      end
    end else if (xfer && !final_pair) begin
      load = 1'b1;
      if (last_pair) begin
        pair_d  = '0;
        stage_d = stage_q + ONE;
      end else begin
        pair_d  = pair_q + 1'b1;
      end
    end
  end

  always_comb begin
    addr1_d  = rotl_n({pair_d, 1'b0}, stage_d, n_d);
    addr2_d  = rotl_n({pair_d, 1'b1}, stage_d, n_d);
    tw_shift = n_d - ONE - stage_d;
    tw_keep  = (pair_d >> tw_shift) << tw_shift;
    tw_d     = tw_keep << (LOG2N_V - n_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      pair_q      <= '0;
      n_q         <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      tw_q        <= '0;
      stage_out_q <= '0;
    end else begin
      stage_q <= stage_d;
      pair_q  <= pair_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (load) begin
        addr1_q     <= addr1_d;
        addr2_q     <= addr2_d;
        tw_q        <= tw_d;
        stage_out_q <= stage_d;
        last_q      <= (pair_d == ~({PW{1'b1}} << (n_d - ONE)));
      end
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign bus.out_valid     = valid_q;
  assign bus.address1      = addr1_q;
  assign bus.address2      = addr2_q;
  assign bus.twiddle_addr  = tw_q;
  assign bus.stage_out     = stage_out_q;
  assign bus.last_in_stage = last_q;
endmodule
